mem_c_deskew: RTL and testbench



---
 rtl/mem_c_pkg.sv | 17 +
 rtl/mem_c_deskew_delay.sv | 38 +++
 rtl/mem_c_deskew.sv | 134 +++++++++++++
 tb/tb_mem_c_deskew.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mem_c_pkg.sv
// Shared types and sizing helpers for the result deskew block.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_c_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // Number of cycles a skewed tile occupies on the array edge (k = 0 .. 2*dim-2).
  function automatic int capture_len(input int dim);
    return 2 * dim - 1;
  endfunction

endpackage

// File: rtl/mem_c_deskew_delay.sv
// Per-column enable-gated delay line; DEPTH = 0 degenerates to a plain wire.
// Latency: DEPTH enabled cycles from d to q.
// Backpressure: none; stages hold their contents while en is low.
module deskew_delay #(
  parameter int DEPTH = 1,
  parameter int BITS  = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic signed [BITS-1:0] d,
  output logic signed [BITS-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      // The last array column is already aligned, so no register is needed.
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst_n, en};
      assign q = d;
    end else begin : g_pipe
      logic signed [BITS-1:0] r_pipe [DEPTH];

      // Shift chain advancing only on capture cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else if (en) begin
          r_pipe[0] <= d;
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end

      assign q = r_pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mem_c_deskew.sv
// Deskews column-skewed array results into a DIM x DIM row buffer, then streams rows out.
// Latency: first row valid 2*DIM-1 cycles after the start cycle.
// Backpressure: out_ready low holds Cout/out_row stable; one row per cycle when ready.
module mem_c_deskew
  import mem_c_pkg::*;
#(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [BITS_C-1:0] Cin [DIM-1:0],
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [BITS_C-1:0] Cout [DIM-1:0],
  output logic [$clog2(DIM)-1:0]   out_row,
  output logic                     busy,
  output logic                     done
);

  localparam int CAP_LEN = capture_len(DIM);
  localparam int KW      = $clog2(CAP_LEN + 1);
  localparam int RW      = $clog2(DIM);

  state_t          r_state, w_state_nxt;
  logic [KW-1:0]   r_k, w_k_nxt;
  logic [RW-1:0]   r_rd, w_rd_nxt;
  logic            r_done, w_done_nxt;

  logic            w_cap;
  logic [KW-1:0]   w_kcur;
  logic            w_wr_en;
  logic [RW-1:0]   w_wrow;
  logic signed [BITS_C-1:0] w_dly [DIM];
  logic signed [BITS_C-1:0] r_buf [DIM][DIM];

  // A capture cycle is either the accepted start cycle (k=0) or any CAPTURE cycle.
  assign w_cap   = ((r_state == IDLE) && start) || (r_state == CAPTURE);
  assign w_kcur  = (r_state == CAPTURE) ? r_k : '0;
  assign w_wr_en = w_cap && (w_kcur >= KW'(DIM - 1));
  assign w_wrow  = RW'(w_kcur - KW'(DIM - 1));

  // Column c waits DIM-1-c cycles so every row lines up at k = r + DIM-1.
  generate
    for (genvar c = 0; c < DIM; c++) begin : g_col
      deskew_delay #(
        .DEPTH (DIM - 1 - c),
        .BITS  (BITS_C)
      ) u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (w_cap),
        .d     (Cin[c]),
        .q     (w_dly[c])
      );
    end
  endgenerate

  // Row buffer capture; contents need no reset because reads are gated by DRAIN.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int c = 0; c < DIM; c++) r_buf[w_wrow][c] <= w_dly[c];
    end
  end

  // State, capture counter, read pointer and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_rd    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_rd    <= w_rd_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: start only counts in IDLE; drain ends on the last row handshake.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_rd_nxt    = r_rd;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = CAPTURE;
          w_k_nxt     = KW'(1);
        end
      end
      CAPTURE: begin
        if (r_k == KW'(CAP_LEN - 1)) begin
          w_state_nxt = DRAIN;
          w_k_nxt     = '0;
        end else begin
          w_k_nxt = r_k + KW'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (r_rd == RW'(DIM - 1)) begin
            w_state_nxt = IDLE;
            w_rd_nxt    = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_rd_nxt = r_rd + RW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_k_nxt     = '0;
        w_rd_nxt    = '0;
      end
    endcase
  end

  // Output row mux; zero outside DRAIN so the bus is quiet between tiles.
  always_comb begin
    for (int c = 0; c < DIM; c++) begin
      Cout[c] = (r_state == DRAIN) ? r_buf[r_rd][c] : '0;
    end
  end

  assign out_valid = (r_state == DRAIN);
  assign out_row   = r_rd;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_mem_c_deskew.sv
// Scoreboard bench for mem_c_deskew at DIM=4, BITS_C=24.
// Latency: rows expected from k=7; done one cycle after the last accepted row.
// Backpressure: out_ready stalls exercised; held rows compared against queue head.
module tb_mem_c_deskew;

  localparam int DIM = 4;
  localparam int BC  = 24;

  typedef struct packed {
    logic [1:0]        row;
    logic [DIM*BC-1:0] dat;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 start;
  logic                 out_ready;
  logic signed [BC-1:0] cin  [DIM-1:0];
  logic signed [BC-1:0] cout [DIM-1:0];
  logic                 out_valid;
  logic [1:0]           out_row;
  logic                 busy;
  logic                 done;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];

  mem_c_deskew #(.BITS_C(BC), .DIM(DIM)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .Cin       (cin),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .Cout      (cout),
    .out_row   (out_row),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait loop is broken.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BC-1:0] elem(input int r, input int c, input bit sgn);
    int v;
    v = sgn ? -(r * 4 + c + 1) : (16 * r + c);
    return BC'(v);
  endfunction

  function automatic logic [DIM*BC-1:0] row_exp(input int r, input bit sgn);
    logic [DIM*BC-1:0] v;
    for (int c = 0; c < DIM; c++) v[c*BC +: BC] = elem(r, c, sgn);
    return v;
  endfunction

  function automatic logic [DIM*BC-1:0] cout_packed();
    logic [DIM*BC-1:0] v;
    for (int c = 0; c < DIM; c++) v[c*BC +: BC] = cout[c];
    return v;
  endfunction

  // Drive one cycle of skewed data: element (r,c) on Cin[c] at k=r+c, filler elsewhere.
  task automatic drive_cin(input int k, input bit sgn, input bit garbage);
    for (int c = 0; c < DIM; c++) begin
      if ((k - c) >= 0 && (k - c) < DIM) cin[c] = elem(k - c, c, sgn);
      else                               cin[c] = garbage ? 24'hFFFFFF : '0;
    end
  endtask

  // mode: 0 basic, 1 backpressure, 3 start-while-busy, 4 garbage outside window.
  task automatic run_tile(input int mode, input bit sgn, input int exp_done);
    int first_k = -1;
    int done_k  = -1;
    bit fin     = 1'b0;
    exp_t e;
    if (mode == 4) begin
      for (int i = 0; i < 2; i++) begin
        @(posedge clk); #1;
        drive_cin(-5, sgn, 1'b1);
      end
    end
    for (int k = 0; k < 30 && !fin; k++) begin
      @(posedge clk); #1;
      start     = (k == 0) || (mode == 3 && (k == 3 || k == 8 || k == 10));
      out_ready = !(mode == 1 && k >= 7 && k <= 9);
      drive_cin(k, sgn, mode == 4);
      if (k == 0) begin
        for (int r = 0; r < DIM; r++) sb_q.push_back('{row: 2'(r), dat: row_exp(r, sgn)});
      end
      if (k == 3) chk("cout_idle", 128'(cout_packed()), 128'(0));
      if (out_valid) begin
        if (first_k < 0) first_k = k;
        if (sb_q.size() == 0) begin
          chk("extra_row", 128'(1), 128'(0));
        end else begin
          e = sb_q[0];
          chk("row_idx", 128'(out_row), 128'(e.row));
          chk("row_dat", 128'(cout_packed()), 128'(e.dat));
          if (out_ready) void'(sb_q.pop_front());
        end
      end
      if (done) begin
        done_k = k;
        chk("busy_at_done", 128'(busy), 128'(0));
        fin = 1'b1;
      end
    end
    start = 1'b0;
    chk("first_valid", 128'(first_k), 128'(7));
    chk("done_cycle", 128'(done_k), 128'(exp_done));
    chk("sb_empty", 128'(sb_q.size()), 128'(0));
    sb_q.delete();
    @(posedge clk); #1;
    chk("done_pulse", 128'(done), 128'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    drive_cin(-5, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_busy",  128'(busy),      128'(0));
    chk("rst_done",  128'(done),      128'(0));
    chk("rst_row",   128'(out_row),   128'(0));
    chk("rst_cout",  128'(cout_packed()), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_tile(0, 1'b0, 11);   // basic tile
    run_tile(1, 1'b0, 14);   // ready low k=7..9
    run_tile(0, 1'b1, 11);   // signed values
    run_tile(3, 1'b0, 11);   // start pulses while busy
    run_tile(4, 1'b0, 11);   // 0xFFFFFF outside the valid cells

    // Abort a signed tile at k=5, then confirm a fresh tile has no residue.
    for (int k = 0; k <= 5; k++) begin
      @(posedge clk); #1;
      start     = (k == 0);
      out_ready = 1'b1;
      drive_cin(k, 1'b1, 1'b0);
    end
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(out_valid), 128'(0));
    chk("abort_busy",  128'(busy),      128'(0));
    chk("abort_done",  128'(done),      128'(0));
    chk("abort_row",   128'(out_row),   128'(0));
    chk("abort_cout",  128'(cout_packed()), 128'(0));
    @(posedge clk); #1;
    chk("abort_done2", 128'(done), 128'(0));
    rst_n = 1'b1;
    drive_cin(-5, 1'b0, 1'b0);
    @(posedge clk); #1;
    run_tile(0, 1'b0, 11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
